// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 set-2 key decoder: protocol
//               byte constants, the prefix-parser state encoding and the
//               decoded-event record carried through the event FIFO.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Protocol bytes seen on the keyboard-to-host channel
  localparam logic [7:0] PS2_EXT    = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_BRK    = 8'hF0;  // break (release) prefix
  localparam logic [7:0] PS2_BAT    = 8'hAA;  // self-test passed
  localparam logic [7:0] PS2_ACK    = 8'hFA;  // command acknowledge
  localparam logic [7:0] PS2_ECHO   = 8'hEE;  // echo reply
  localparam logic [7:0] PS2_RESEND = 8'hFE;  // resend request
  localparam logic [7:0] PS2_ERR0   = 8'h00;  // key detection error / overrun
  localparam logic [7:0] PS2_ERR1   = 8'hFF;  // key detection error / overrun

  // Prefix parser state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // One decoded key event, prefixes stripped
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

  // Error bytes abort any pending prefix sequence
  function automatic logic ps2_is_line_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  // Keyboard replies to host commands; never part of a key sequence
  // when they arrive outside a prefix
  function automatic logic ps2_is_ctrl_reply(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : Synchronous show-ahead FIFO with a registered head word.
//               A push into a full FIFO is accepted only if a pop happens in
//               the same cycle; otherwise the word is dropped and a sticky
//               overflow flag is raised until reset.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push, i_data - write strobe and word
//               i_pop          - consume head word (ignored when empty)
//               o_valid        - FIFO non-empty
//               o_data         - head word (registered)
//               o_count        - occupancy, 0..DEPTH
//               o_overflow     - sticky drop indicator
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_drop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL);
  assign w_pop_ok  = i_pop && !w_empty;
  // A simultaneous pop frees the slot the push needs, even when full
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign w_drop    = i_push && !w_push_ok;

  assign w_rd_ptr_nxt = w_pop_ok ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // The head register must see the new word when it lands exactly at the
  // slot that becomes the head (empty FIFO, or one entry popped while
  // another is pushed); otherwise it reads the stored word.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = i_data;
    end
  end

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_head   <= w_head_nxt;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = r_head;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Turns the raw PS/2 set-2 byte stream into make/break events.
//               Handles the E0 (extended) and F0 (break) prefixes, tracks a
//               held bitmap for a table of keys and buffers every event in a
//               FIFO with a valid/ready handshake. A pending prefix that is
//               not followed by another byte within TIMEOUT_CYCLES is
//               abandoned.
// Ports       : inclock, reset            - clock, sync active-high reset
//               ps2_key_data, ps2_key_pressed - received byte and its strobe
//               evt_ready                 - consumer accepts head event
//               evt_valid, evt_code, evt_break, evt_ext - head event
//               key_held                  - per-key held bitmap
//               last_make_code            - latest non-extended make
//               fifo_count, fifo_overflow - occupancy, sticky drop flag
// Options     : PS2_TYPEMATIC_FILTER_EN - when defined, a make for a tracked
//               key that is already held is not queued (auto-repeat
//               suppression); held tracking is unaffected.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h1D, 8'h1B, 8'h75, 8'h72},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1100,
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                        inclock,
  input  logic                        reset,
  input  logic [7:0]                  ps2_key_data,
  input  logic                        ps2_key_pressed,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_break,
  output logic                        evt_ext,
  output logic [NUM_KEYS-1:0]         key_held,
  output logic [7:0]                  last_make_code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_overflow
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e          r_state;
  ps2_state_e          w_state_nxt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [TO_W-1:0]     w_to_cnt_nxt;
  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] w_held_nxt;
  logic [7:0]          r_last_make;

  ps2_evt_t            w_evt;
  logic                w_evt_fire;
  logic [NUM_KEYS-1:0] w_match;
  logic                w_repeat;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_valid;
  ps2_evt_t            w_head;

  // --------------------------------------------------------------------------
  // Parser state register
  // --------------------------------------------------------------------------
  always_ff @(posedge inclock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Parser next state and event decode. A strobe always wins over the
  // timeout, so a byte arriving on the final cycle still completes the
  // sequence.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    w_evt_fire   = 1'b0;
    w_evt        = '0;
    w_evt.code   = ps2_key_data;

    if (ps2_key_pressed) begin
      w_to_cnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (ps2_key_data == PS2_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (ps2_key_data == PS2_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (ps2_is_line_err(ps2_key_data) || ps2_is_ctrl_reply(ps2_key_data)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_evt_fire = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_key_data == PS2_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (ps2_key_data == PS2_EXT) begin
            // Repeated E0 keeps the extended prefix pending
            w_state_nxt = ST_EXT;
          end else if (ps2_is_line_err(ps2_key_data)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_evt_fire  = 1'b1;
            w_evt.ext   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (!((ps2_key_data == PS2_EXT) || (ps2_key_data == PS2_BRK) ||
                ps2_is_line_err(ps2_key_data))) begin
            w_evt_fire = 1'b1;
            w_evt.brk  = 1'b1;
            w_evt.ext  = (r_state == ST_EXT_BRK);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_to_cnt == C_TO_LAST) begin
        w_state_nxt  = ST_IDLE;
        w_to_cnt_nxt = '0;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end
    end else begin
      w_to_cnt_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Key table lookup; duplicate entries simply match together
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
    assign w_match[gi] = (w_evt.code == KEY_CODES[gi*8 +: 8]) && (w_evt.ext == KEY_EXT[gi]);
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // A make for a key already down is keyboard auto-repeat
  assign w_repeat = !w_evt.brk && |(w_match & r_held);
`else
  assign w_repeat = 1'b0;
`endif

  assign w_push = w_evt_fire && !w_repeat;
  assign w_pop  = w_fifo_valid && evt_ready;

  // Held tracking follows every decoded event, whether or not it is queued
  always_comb begin
    w_held_nxt = r_held;
    if (w_evt_fire) begin
      if (w_evt.brk) begin
        w_held_nxt = r_held & ~w_match;
      end else begin
        w_held_nxt = r_held | w_match;
      end
    end
  end

  always_ff @(posedge inclock) begin
    if (reset) begin
      r_held      <= '0;
      r_last_make <= '0;
    end else begin
      r_held <= w_held_nxt;
      if (w_evt_fire && !w_evt.brk && !w_evt.ext) begin
        r_last_make <= w_evt.code;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event buffer
  // --------------------------------------------------------------------------
  ps2_event_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (inclock),
    .rst        (reset),
    .i_push     (w_push),
    .i_data     (w_evt),
    .i_pop      (w_pop),
    .o_valid    (w_fifo_valid),
    .o_data     (w_head),
    .o_count    (fifo_count),
    .o_overflow (fifo_overflow)
  );

  assign evt_valid      = w_fifo_valid;
  assign evt_code       = w_head.code;
  assign evt_break      = w_head.brk;
  assign evt_ext        = w_head.ext;
  assign key_held       = r_held;
  assign last_make_code = r_last_make;

endmodule
`default_nettype wire
